// File: rtl/updown_counter_param_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
package updown_counter_param_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  function automatic int clog2(input longint value);
    int     bits;
    longint v;
    bits = 0;
    v    = value - 1;
    while (v > 0) begin
      bits = bits + 1;
      v    = v >> 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/updown_counter_param_next.sv
// Combinational next-count and boundary detection for the up/down counter.
module updown_next
  import updown_counter_param_pkg::*;
#(
  parameter int     WIDTH    = 3,
  parameter longint MODULUS  = 8,
  parameter int     SATURATE = MODE_WRAP
) (
  input  logic [WIDTH-1:0] q,
  input  logic             m,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_next,
  output logic             boundary
);

  // One extra bit so MODULUS = 2**WIDTH is representable.
  localparam logic [WIDTH:0] MOD_EXT  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0] LAST_EXT = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] LAST   = LAST_EXT[WIDTH-1:0];

  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] d_ext;

  assign q_ext = {1'b0, q};
  assign d_ext = {1'b0, d};

  always_comb begin
    q_next   = q;
    boundary = 1'b0;
    if (load) begin
      q_next = (d_ext < MOD_EXT) ? d : LAST;
    end else if (en) begin
      if (m == DIR_UP) begin
        if (q_ext < LAST_EXT) begin
          q_next = q + WIDTH'(1);
        end else begin
          boundary = 1'b1;
          q_next   = (SATURATE == MODE_SAT) ? q : '0;
        end
      end else begin
        if (q != '0) begin
          q_next = q - WIDTH'(1);
        end else begin
          boundary = 1'b1;
          q_next   = (SATURATE == MODE_SAT) ? q : LAST;
        end
      end
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// WIDTH-bit modulo-N up/down counter with load, wrap/saturate, tc pulse and sticky ovf.
module updown_counter_param
  import updown_counter_param_pkg::*;
#(
  parameter int     WIDTH    = 3,
  parameter longint MODULUS  = 8,
  parameter int     SATURATE = MODE_WRAP
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             m,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("updown_counter_param: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("updown_counter_param: MODULUS must be 2..2**WIDTH");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             boundary;

  updown_next #(
    .WIDTH    (WIDTH),
    .MODULUS  (MODULUS),
    .SATURATE (SATURATE)
  ) u_next (
    .q        (count_q),
    .m        (m),
    .en       (en),
    .load     (load),
    .d        (d),
    .q_next   (count_d),
    .boundary (boundary)
  );

  // boundary is never raised on load or idle cycles, so tc clears there too.
  always_comb begin
    tc_d  = boundary;
    ovf_d = load ? 1'b0 : (ovf_q | boundary);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign q   = count_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed bench: a wrapping mod-8 and a saturating mod-6 counter driven in parallel.
module tb_updown_counter_param;

  logic       clk = 1'b0;
  logic       clr, en, m, load;
  logic [2:0] d;
  logic [2:0] q_w, q_s;
  logic       tc_w, tc_s, ovf_w, ovf_s;

  int total = 0;
  int bad   = 0;

  int mw_q = 0, mw_tc = 0, mw_ovf = 0;
  int ms_q = 0, ms_tc = 0, ms_ovf = 0;

  always #5 clk = ~clk;

  updown_counter_param #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_wrap (
    .clk(clk), .clr(clr), .en(en), .m(m), .load(load), .d(d),
    .q(q_w), .tc(tc_w), .ovf(ovf_w)
  );

  updown_counter_param #(.WIDTH(3), .MODULUS(6), .SATURATE(1)) u_sat (
    .clk(clk), .clr(clr), .en(en), .m(m), .load(load), .d(d),
    .q(q_s), .tc(tc_s), .ovf(ovf_s)
  );

  task automatic check(input string name, input int act, input int exp);
    total = total + 1;
    if (act != exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: step the count as signed integer arithmetic, then resolve
  // anything that left 0..modv-1 as either a wrap or a hold.
  function automatic void model_step(input int modv, input bit satv,
                                     inout int mq, inout int mtc, inout int movf);
    int nq;
    if (load) begin
      mq   = (int'(d) < modv) ? int'(d) : modv - 1;
      mtc  = 0;
      movf = 0;
    end else if (en) begin
      nq = m ? mq - 1 : mq + 1;
      if (nq < 0 || nq >= modv) begin
        mtc  = 1;
        movf = 1;
        nq   = satv ? mq : (nq + modv) % modv;
      end else begin
        mtc = 0;
      end
      mq = nq;
    end else begin
      mtc = 0;
    end
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      mw_q = 0; mw_tc = 0; mw_ovf = 0;
      ms_q = 0; ms_tc = 0; ms_ovf = 0;
    end else begin
      model_step(8, 1'b0, mw_q, mw_tc, mw_ovf);
      model_step(6, 1'b1, ms_q, ms_tc, ms_ovf);
    end
  end

  always @(negedge clk) begin
    check("model_wrap_q",   int'(q_w),   mw_q);
    check("model_wrap_tc",  int'(tc_w),  mw_tc);
    check("model_wrap_ovf", int'(ovf_w), mw_ovf);
    check("model_sat_q",    int'(q_s),   ms_q);
    check("model_sat_tc",   int'(tc_s),  ms_tc);
    check("model_sat_ovf",  int'(ovf_s), ms_ovf);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_w(input string name, input int eq, input int etc, input int eovf);
    check({name, "_wq"},   int'(q_w),   eq);
    check({name, "_wtc"},  int'(tc_w),  etc);
    check({name, "_wovf"}, int'(ovf_w), eovf);
  endtask

  task automatic expect_s(input string name, input int eq, input int etc, input int eovf);
    check({name, "_sq"},   int'(q_s),   eq);
    check({name, "_stc"},  int'(tc_s),  etc);
    check({name, "_sovf"}, int'(ovf_s), eovf);
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; m = 1'b0; load = 1'b0; d = 3'd0;
    #3;
    expect_w("reset", 0, 0, 0);
    expect_s("reset", 0, 0, 0);
    tick();
    tick();
    clr = 1'b0;

    // wrap upwards through 7 -> 0
    en = 1'b1; m = 1'b0;
    for (int k = 1; k <= 7; k++) tick();
    expect_w("up7", 7, 0, 0);
    expect_s("up7", 5, 1, 1);
    tick();
    expect_w("wrap0", 0, 1, 1);
    tick();
    expect_w("after_wrap", 1, 0, 1);

    // down from 0 wraps to 7, then reverse without a gap
    load = 1'b1; en = 1'b0; d = 3'd0;
    tick();
    expect_w("load0", 0, 0, 0);
    load = 1'b0; en = 1'b1; m = 1'b1;
    tick();
    expect_w("down7", 7, 1, 1);
    expect_s("down_sat0", 0, 1, 1);
    tick();
    expect_w("down6", 6, 0, 1);
    tick();
    expect_w("down5", 5, 0, 1);
    m = 1'b0;
    tick();
    expect_w("reverse6", 6, 0, 1);

    // clamped load and sustained saturation
    load = 1'b1; en = 1'b0; d = 3'd7;
    tick();
    expect_s("clamp", 5, 0, 0);
    expect_w("load7", 7, 0, 0);
    load = 1'b0; en = 1'b1; m = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_s("sat_hold", 5, 1, 1);
    end
    m = 1'b1;
    tick();
    expect_s("sat_down", 4, 0, 1);

    // load beats enable
    load = 1'b1; en = 1'b1; d = 3'd3; m = 1'b0;
    tick();
    expect_w("load_en", 3, 0, 0);
    expect_s("load_en", 3, 0, 0);
    load = 1'b0;

    // async clear between edges while q=6
    for (int k = 0; k < 3; k++) tick();
    expect_w("pre_clr", 6, 0, 0);
    #2;
    clr = 1'b1;
    #1;
    expect_w("async_clr", 0, 0, 0);
    expect_s("async_clr", 0, 0, 0);
    clr = 1'b0;
    tick();
    expect_w("resume", 1, 0, 0);

    // idle with direction toggling
    en = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m = ~m;
      tick();
      expect_w("idle", 1, 0, 0);
      expect_s("idle", 1, 0, 0);
    end

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
